// File: rtl/servant_arbiter_rr.sv
// Wishbone arbiter sharing one slave port among NUM_MASTERS masters, round-robin or fixed priority.
// Latency: grant one cycle after request; master ack combinational from slave ack; error ack in BUSY cycle TIMEOUT+1.
// Backpressure: masters hold cyc until ack; non-owners wait in IDLE arbitration; late slave acks are dropped.
module servant_arbiter_rr #(
    parameter int NUM_MASTERS   = 3,
    parameter int AW            = 32,
    parameter int DW            = 32,
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT       = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_MASTERS*AW-1:0]   i_m_adr,
    input  logic [NUM_MASTERS*DW-1:0]   i_m_dat,
    input  logic [NUM_MASTERS*DW/8-1:0] i_m_sel,
    input  logic [NUM_MASTERS-1:0]      i_m_we,
    input  logic [NUM_MASTERS-1:0]      i_m_cyc,
    output logic [DW-1:0]               o_m_rdt,
    output logic [NUM_MASTERS-1:0]      o_m_ack,
    output logic [NUM_MASTERS-1:0]      o_m_err,
    output logic [AW-1:0]               o_s_adr,
    output logic [DW-1:0]               o_s_dat,
    output logic [DW/8-1:0]             o_s_sel,
    output logic                        o_s_we,
    output logic                        o_s_cyc,
    input  logic [DW-1:0]               i_s_rdt,
    input  logic                        i_s_ack,
    output logic [NUM_MASTERS-1:0]      o_grant
);

    localparam int OW = $clog2(NUM_MASTERS);
    // A zero-width counter is not legal, so keep one bit when the timeout is disabled
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [OW-1:0] owner, owner_nxt;
    logic [OW-1:0] last, last_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [OW-1:0] winner;
    logic [OW-1:0] cand;
    logic          found;
    logic          owner_cyc;
    logic          timed_out;

    assign owner_cyc = i_m_cyc[owner];
    assign timed_out = (TIMEOUT > 0) && (cnt == CW'(TIMEOUT));

    // Choose the next owner: lowest index, or first requester after the last served master
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        if (PRIORITY_MODE == 1) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                cand = OW'(i);
                if (i_m_cyc[cand]) begin
                    winner = cand;
                end
            end
        end else begin
            for (int i = 1; i <= NUM_MASTERS; i++) begin
                cand = OW'((int'(last) + i) % NUM_MASTERS);
                if (!found && i_m_cyc[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
            end
        end
    end

    // Route the owner's request fields to the slave; stable for all of BUSY since owner is fixed there
    always_comb begin
        o_s_adr = '0;
        o_s_dat = '0;
        o_s_sel = '0;
        o_s_we  = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (owner == OW'(k)) begin
                o_s_adr = i_m_adr[k*AW +: AW];
                o_s_dat = i_m_dat[k*DW +: DW];
                o_s_sel = i_m_sel[k*(DW/8) +: (DW/8)];
                o_s_we  = i_m_we[k];
            end
        end
    end

    // Next-state and handshake outputs: abort beats timeout, timeout beats a same-cycle slave ack
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = cnt;
        o_s_cyc   = 1'b0;
        o_m_ack   = '0;
        o_m_err   = '0;
        o_m_rdt   = i_s_rdt;
        o_grant   = '0;
        case (state)
            IDLE: begin
                if (|i_m_cyc) begin
                    owner_nxt = winner;
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                o_grant[owner] = 1'b1;
                if (!owner_cyc) begin
                    // Master gave up; the slave never saw a request this cycle, so no ack
                    state_nxt = IDLE;
                end else if (timed_out) begin
                    o_m_ack[owner] = 1'b1;
                    o_m_err[owner] = 1'b1;
                    o_m_rdt        = '0;
                    last_nxt       = owner;
                    state_nxt      = IDLE;
                end else begin
                    o_s_cyc = 1'b1;
                    if (i_s_ack) begin
                        o_m_ack[owner] = 1'b1;
                        last_nxt       = owner;
                        state_nxt      = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, owner, round-robin pointer and timeout counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            owner <= '0;
            last  <= OW'(NUM_MASTERS - 1);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_servant_arbiter_rr.sv
// Bench for servant_arbiter_rr: directed scenarios plus random traffic against a transaction-level model.
// Latency: checks sampled on the falling edge, inputs driven 1ns after the rising edge.
// Backpressure: bench plays masters (hold cyc until ack) and a slave with chosen ack latency.
module tb_servant_arbiter_rr;

    localparam int N  = 3;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*32-1:0] m_adr, m_dat;
    logic [N*4-1:0]  m_sel;
    logic [N-1:0]  m_we, m_cyc;
    logic [31:0]   s_rdt;
    logic          s_ack;

    logic [31:0]   rr_rdt, rr_s_adr, rr_s_dat;
    logic [N-1:0]  rr_ack, rr_err, rr_grant;
    logic [3:0]    rr_s_sel;
    logic          rr_s_we, rr_s_cyc;

    logic [31:0]   fp_rdt, fp_s_adr, fp_s_dat;
    logic [N-1:0]  fp_ack, fp_err, fp_grant;
    logic [3:0]    fp_s_sel;
    logic          fp_s_we, fp_s_cyc;

    int n_cmp = 0;
    int n_err = 0;

    // random-phase state
    logic [N-1:0]  pending;
    logic [31:0]   r_adr [N];
    logic [31:0]   r_dat [N];
    logic [3:0]    r_sel [N];
    logic          r_we  [N];
    int            mlast, expo, lat, c;
    logic [31:0]   rdt_drv;
    bit            done, stray;

    always #5 clk = ~clk;

    servant_arbiter_rr #(.NUM_MASTERS(N), .AW(32), .DW(32), .PRIORITY_MODE(0), .TIMEOUT(TO)) u_rr (
        .i_clk(clk), .i_rst(rst),
        .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel), .i_m_we(m_we), .i_m_cyc(m_cyc),
        .o_m_rdt(rr_rdt), .o_m_ack(rr_ack), .o_m_err(rr_err),
        .o_s_adr(rr_s_adr), .o_s_dat(rr_s_dat), .o_s_sel(rr_s_sel), .o_s_we(rr_s_we), .o_s_cyc(rr_s_cyc),
        .i_s_rdt(s_rdt), .i_s_ack(s_ack), .o_grant(rr_grant)
    );

    servant_arbiter_rr #(.NUM_MASTERS(N), .AW(32), .DW(32), .PRIORITY_MODE(1), .TIMEOUT(TO)) u_fp (
        .i_clk(clk), .i_rst(rst),
        .i_m_adr(m_adr), .i_m_dat(m_dat), .i_m_sel(m_sel), .i_m_we(m_we), .i_m_cyc(m_cyc),
        .o_m_rdt(fp_rdt), .o_m_ack(fp_ack), .o_m_err(fp_err),
        .o_s_adr(fp_s_adr), .o_s_dat(fp_s_dat), .o_s_sel(fp_s_sel), .o_s_we(fp_s_we), .o_s_cyc(fp_s_cyc),
        .i_s_rdt(s_rdt), .i_s_ack(s_ack), .o_grant(fp_grant)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    // Leaves the bench in cycle 0: IDLE, reset released, no requests yet
    task automatic do_reset();
        rst   = 1'b1;
        m_cyc = '0;
        s_ack = 1'b0;
        go();
        go();
        rst = 1'b0;
    endtask

    function automatic logic [N-1:0] oh(input int k);
        return N'(1 << k);
    endfunction

    // Round-robin winner: the requester at the smallest forward distance from the last served master
    function automatic int model_pick(input logic [N-1:0] req, input int last_k);
        int best, best_d, d;
        best   = -1;
        best_d = N;
        for (int k = 0; k < N; k++) begin
            if (req[k]) begin
                d = (k - last_k - 1 + 2 * N) % N;
                if (d < best_d) begin
                    best_d = d;
                    best   = k;
                end
            end
        end
        return best;
    endfunction

    initial begin
        rst   = 1'b1;
        m_adr = '0;
        m_dat = '0;
        m_sel = '0;
        m_we  = '0;
        m_cyc = '0;
        s_rdt = '0;
        s_ack = 1'b0;

        // ---- reset state ----
        go();
        go();
        look();
        chk("rst_rr_grant", rr_grant, 0);
        chk("rst_rr_scyc", rr_s_cyc, 0);
        chk("rst_rr_ack", rr_ack, 0);
        chk("rst_rr_err", rr_err, 0);
        chk("rst_fp_grant", fp_grant, 0);
        chk("rst_fp_scyc", fp_s_cyc, 0);

        // ---- single master m1 read ----
        do_reset();
        m_cyc = 3'b010;
        m_adr[63:32] = 32'h10;
        m_sel = '1;
        look();
        chk("t1_c0_grant", rr_grant, 0);
        chk("t1_c0_scyc", rr_s_cyc, 0);
        go();
        look();
        chk("t1_c1_grant", rr_grant, 3'b010);
        chk("t1_c1_scyc", rr_s_cyc, 1);
        chk("t1_c1_sadr", rr_s_adr, 32'h10);
        chk("t1_c1_ack", rr_ack, 0);
        go();
        s_ack = 1'b1;
        s_rdt = 32'hCAFEF00D;
        look();
        chk("t1_c2_ack", rr_ack, 3'b010);
        chk("t1_c2_err", rr_err, 0);
        chk("t1_c2_rdt", rr_rdt, 32'hCAFEF00D);
        chk("t1_c2_sadr", rr_s_adr, 32'h10);
        go();
        s_ack = 1'b0;
        m_cyc = '0;
        look();
        chk("t1_c3_grant", rr_grant, 0);
        chk("t1_c3_scyc", rr_s_cyc, 0);

        // ---- round-robin fairness, all masters hold cyc ----
        do_reset();
        m_adr = {32'h300, 32'h200, 32'h100};
        m_cyc = 3'b111;
        for (int g = 0; g < 6; g++) begin
            look();
            chk("t2_idle_grant", rr_grant, 0);
            go();
            look();
            chk("t2_b1_grant", rr_grant, oh(g % 3));
            chk("t2_b1_sadr", rr_s_adr, 32'((g % 3 + 1) * 256));
            go();
            s_ack = 1'b1;
            look();
            chk("t2_b2_grant", rr_grant, oh(g % 3));
            chk("t2_b2_ack", rr_ack, oh(g % 3));
            go();
            s_ack = 1'b0;
        end

        // ---- fixed priority, same stimulus ----
        do_reset();
        m_cyc = 3'b111;
        for (int g = 0; g < 6; g++) begin
            look();
            chk("t3_idle_ack", fp_ack, 0);
            go();
            look();
            chk("t3_b1_grant", fp_grant, 3'b001);
            chk("t3_b1_ack", fp_ack, 0);
            go();
            s_ack = 1'b1;
            look();
            chk("t3_b2_ack", fp_ack, 3'b001);
            go();
            s_ack = 1'b0;
        end

        // ---- timeout: slave never acks ----
        do_reset();
        m_cyc = 3'b100;
        s_rdt = 32'hDEADBEEF;
        go();
        for (int k = 1; k <= TO; k++) begin
            look();
            chk("t4_scyc_busy", rr_s_cyc, 1);
            chk("t4_ack_busy", rr_ack, 0);
            go();
        end
        s_ack = 1'b1;
        look();
        chk("t4_err_ack", rr_ack, 3'b100);
        chk("t4_err_err", rr_err, 3'b100);
        chk("t4_err_rdt", rr_rdt, 0);
        chk("t4_err_scyc", rr_s_cyc, 0);
        go();
        m_cyc = '0;
        s_ack = 1'b1;
        look();
        chk("t4_late_ack", rr_ack, 0);
        chk("t4_late_err", rr_err, 0);
        go();
        s_ack = 1'b0;

        // ---- ack in cycle TIMEOUT wins over timeout ----
        do_reset();
        m_cyc = 3'b001;
        go();
        for (int k = 1; k < TO; k++) begin
            look();
            chk("t5_ack_wait", rr_ack, 0);
            go();
        end
        s_ack = 1'b1;
        s_rdt = 32'h12345678;
        look();
        chk("t5_ack", rr_ack, 3'b001);
        chk("t5_err", rr_err, 0);
        chk("t5_rdt", rr_rdt, 32'h12345678);
        go();
        s_ack = 1'b0;
        m_cyc = '0;
        look();
        chk("t5_idle_grant", rr_grant, 0);

        // ---- abort: m0 drops cyc in cycle 1 ----
        do_reset();
        m_cyc = 3'b011;
        go();
        m_cyc = 3'b010;
        look();
        chk("t6_c1_ack", rr_ack, 0);
        chk("t6_c1_scyc", rr_s_cyc, 0);
        go();
        look();
        chk("t6_c2_grant", rr_grant, 0);
        chk("t6_c2_ack", rr_ack, 0);
        go();
        look();
        chk("t6_c3_grant", rr_grant, 3'b010);
        go();
        s_ack = 1'b1;
        look();
        chk("t6_c4_ack", rr_ack, 3'b010);
        go();
        s_ack = 1'b0;
        m_cyc = '0;

        // ---- reset during BUSY ----
        do_reset();
        m_cyc = 3'b110;
        go();
        look();
        chk("t7_c1_grant", rr_grant, 3'b010);
        go();
        rst = 1'b1;
        go();
        rst = 1'b0;
        m_cyc = 3'b111;
        look();
        chk("t7_post_grant", rr_grant, 0);
        chk("t7_post_scyc", rr_s_cyc, 0);
        chk("t7_post_ack", rr_ack, 0);
        chk("t7_post_err", rr_err, 0);
        go();
        look();
        chk("t7_next_grant", rr_grant, 3'b001);
        go();
        s_ack = 1'b1;
        look();
        chk("t7_next_ack", rr_ack, 3'b001);
        go();
        s_ack = 1'b0;
        m_cyc = '0;

        // ---- random traffic against the transaction model ----
        do_reset();
        mlast   = N - 1;
        pending = '0;
        for (int k = 0; k < N; k++) begin
            r_adr[k] = '0;
            r_dat[k] = '0;
            r_sel[k] = '0;
            r_we[k]  = 1'b0;
        end
        for (int t = 0; t < 60; t++) begin
            for (int k = 0; k < N; k++) begin
                if (!pending[k] && ($urandom_range(0, 1) == 1)) begin
                    pending[k] = 1'b1;
                    r_adr[k]   = $urandom;
                    r_dat[k]   = $urandom;
                    r_sel[k]   = 4'($urandom_range(1, 15));
                    r_we[k]    = 1'($urandom_range(0, 1));
                end
            end
            if (pending == '0) begin
                pending[0] = 1'b1;
                r_adr[0]   = $urandom;
            end
            for (int k = 0; k < N; k++) begin
                m_adr[k*32 +: 32] = r_adr[k];
                m_dat[k*32 +: 32] = r_dat[k];
                m_sel[k*4 +: 4]   = r_sel[k];
                m_we[k]           = r_we[k];
            end
            m_cyc = pending;
            stray = ($urandom_range(0, 3) == 0);
            s_ack = stray;
            look();
            chk("rnd_idle_grant", rr_grant, 0);
            chk("rnd_idle_ack", rr_ack, 0);
            expo = model_pick(pending, mlast);
            lat  = int'($urandom_range(1, 6));
            c    = 0;
            done = 1'b0;
            while (!done) begin
                c++;
                go();
                s_ack   = (c == lat) && (lat <= TO);
                rdt_drv = $urandom | 32'h1;
                s_rdt   = rdt_drv;
                look();
                chk("rnd_grant", rr_grant, oh(expo));
                chk("rnd_sadr", rr_s_adr, r_adr[expo]);
                chk("rnd_sdat", rr_s_dat, r_dat[expo]);
                chk("rnd_ssel", rr_s_sel, r_sel[expo]);
                chk("rnd_swe", rr_s_we, r_we[expo]);
                if ((c == lat) && (lat <= TO)) begin
                    chk("rnd_ack", rr_ack, oh(expo));
                    chk("rnd_err0", rr_err, 0);
                    chk("rnd_rdt", rr_rdt, rdt_drv);
                    done = 1'b1;
                end else if (c == TO + 1) begin
                    chk("rnd_to_ack", rr_ack, oh(expo));
                    chk("rnd_to_err", rr_err, oh(expo));
                    chk("rnd_to_rdt", rr_rdt, 0);
                    chk("rnd_to_scyc", rr_s_cyc, 0);
                    done = 1'b1;
                end else begin
                    chk("rnd_wait_ack", rr_ack, 0);
                    chk("rnd_wait_scyc", rr_s_cyc, 1);
                end
            end
            mlast         = expo;
            pending[expo] = 1'b0;
            go();
            s_ack = 1'b0;
        end
        m_cyc = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
